// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD operand loader.
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational BCD range check: flags nibbles A-F as invalid digits.
module bcd_digit_check
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic             invalid
);

   assign invalid = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_operand_loader.sv
// Assembles two DIGITS-wide packed BCD operands (MSD first) and presents them
// to the adder. Build option BCD_LOADER_STRICT_EN discards a pair on any invalid digit.
//
// state  | meaning
// LOAD_A | shifting digits into operand A
// LOAD_B | shifting digits into operand B
// HOLD   | pair complete, op_valid high until op_ready
module bcd_operand_loader
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BCD_W-1:0]        dig_in,
   input  logic                    dig_valid,
   output logic                    dig_ready,
   output logic [BCD_W*DIGITS-1:0] op_a,
   output logic [BCD_W*DIGITS-1:0] op_b,
   output logic                    op_valid,
   input  logic                    op_ready,
   output logic                    op_err,
   output logic                    err_sticky,
   input  logic                    err_clr
);

   localparam int OP_W  = BCD_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OP_W-1:0]   op_a_q, op_a_d;
   logic [OP_W-1:0]   op_b_q, op_b_d;
   logic              op_err_q, op_err_d;
   logic              sticky_q, sticky_d;
   logic              invalid;
   logic              accept;
   logic              discard;

   bcd_digit_check u_check (
      .digit   (dig_in),
      .invalid (invalid)
   );

`ifdef BCD_LOADER_STRICT_EN
   assign discard = invalid;
`else
   assign discard = 1'b0;
`endif

   assign dig_ready  = (state_q != HOLD) && !rst;
   assign accept     = dig_valid && dig_ready;
   assign op_valid   = (state_q == HOLD);
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign op_err     = op_err_q;
   assign err_sticky = sticky_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_err_d = op_err_q;
      sticky_d = sticky_q;

      // set wins over a simultaneous clear
      if (err_clr)
         sticky_d = 1'b0;
      if (accept && invalid)
         sticky_d = 1'b1;

      case (state_q)
         LOAD_A, LOAD_B: begin
            if (accept) begin
               if (discard) begin
                  state_d  = LOAD_A;
                  cnt_d    = '0;
                  op_a_d   = '0;
                  op_b_d   = '0;
                  op_err_d = 1'b0;
               end else begin
                  if (state_q == LOAD_A) begin
                     op_a_d              = op_a_q << BCD_W;
                     op_a_d[BCD_W-1:0]   = dig_in;
                  end else begin
                     op_b_d              = op_b_q << BCD_W;
                     op_b_d[BCD_W-1:0]   = dig_in;
                  end
                  if (invalid)
                     op_err_d = 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            if (op_ready) begin
               state_d  = LOAD_A;
               op_err_d = 1'b0;
            end
         end
         default: begin
            state_d = LOAD_A;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD_A;
         cnt_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_err_q <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_err_q <= op_err_d;
         sticky_q <= sticky_d;
      end
   end

endmodule
